// File: rtl/logic_unit_arbiter.sv
// Shared 2-input bitwise logic unit (AND/OR/XOR/NAND) with round-robin
// arbitration among N requesters. Each operation runs IDLE -> EXEC -> DONE.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | unit free; arbitrate req from ptr, capture winner's operands
// EXEC  | winner owns the unit; registered result computed this cycle
// DONE  | done pulse to winner, result valid; ptr moves past the winner
module logic_unit_arbiter #(
    parameter int N     = 4,
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N*WIDTH-1:0]   op_a,
    input  logic [N*WIDTH-1:0]   op_b,
    input  logic [N*2-1:0]       opcode,
    output logic [N-1:0]         gnt,
    output logic [N-1:0]         done,
    output logic [WIDTH-1:0]     result,
    output logic                 busy
);

    localparam int            IW  = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW:0]   N_W = (IW+1)'(N);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [N-1:0]       gnt_q, gnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [1:0]         opc_q, opc_d;
    logic [WIDTH-1:0]   result_q, result_d;

    logic [2*N-1:0]     req_dbl;
    logic [N-1:0]       req_rot;
    logic               win_found;
    logic [IW:0]        win_off;
    logic [IW:0]        win_sum;
    logic [IW-1:0]      win_idx;
    logic [N-1:0]       win_onehot;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic [1:0]         sel_op;
    logic [IW:0]        ptr_nxt;

    // Round-robin pick: rotate req so ptr sits at bit 0, take the first set
    // bit, then map the offset back to an absolute requester index.
    always_comb begin
        req_dbl   = {req, req} >> ptr_q;
        req_rot   = req_dbl[N-1:0];
        win_found = 1'b0;
        win_off   = '0;
        for (int k = 0; k < N; k++) begin
            if (!win_found && req_rot[k]) begin
                win_found = 1'b1;
                win_off   = (IW+1)'(k);
            end
        end
        win_sum = {1'b0, ptr_q} + win_off;
        if (win_sum >= N_W) begin
            win_sum = win_sum - N_W;
        end
        win_idx    = win_sum[IW-1:0];
        win_onehot = '0;
        sel_a      = '0;
        sel_b      = '0;
        sel_op     = '0;
        for (int k = 0; k < N; k++) begin
            if (win_idx == IW'(k)) begin
                win_onehot[k] = 1'b1;
                sel_a         = op_a[k*WIDTH +: WIDTH];
                sel_b         = op_b[k*WIDTH +: WIDTH];
                sel_op        = opcode[k*2 +: 2];
            end
        end
        ptr_nxt = {1'b0, idx_q} + (IW+1)'(1);
        if (ptr_nxt >= N_W) begin
            ptr_nxt = '0;
        end
    end

    // Sequencer next-state and datapath updates.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        gnt_d    = gnt_q;
        a_d      = a_q;
        b_d      = b_q;
        opc_d    = opc_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d = ST_EXEC;
                    idx_d   = win_idx;
                    gnt_d   = win_onehot;
                    a_d     = sel_a;
                    b_d     = sel_b;
                    opc_d   = sel_op;
                end
            end
            ST_EXEC: begin
                case (opc_q)
                    2'b00:   result_d = a_q & b_q;
                    2'b01:   result_d = a_q | b_q;
                    2'b10:   result_d = a_q ^ b_q;
                    default: result_d = ~(a_q & b_q);
                endcase
                state_d = ST_DONE;
            end
            ST_DONE: begin
                ptr_d   = ptr_nxt[IW-1:0];
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            idx_q    <= '0;
            gnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            opc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            gnt_q    <= gnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            opc_q    <= opc_d;
            result_q <= result_d;
        end
    end

    assign gnt    = gnt_q;
    assign done   = (state_q == ST_DONE) ? gnt_q : '0;
    assign busy   = (state_q != ST_IDLE);
    assign result = result_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed and randomized checks of logic_unit_arbiter against a
// transaction-level reference model.
module tb_logic_unit_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic [N*W-1:0]   op_a;
    logic [N*W-1:0]   op_b;
    logic [N*2-1:0]   opcode;
    logic [N-1:0]     gnt;
    logic [N-1:0]     done;
    logic [W-1:0]     result;
    logic             busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Reference model: cycles left in the current operation (0 = free).
    int           m_left  = 0;
    int           m_owner = 0;
    int           m_ptr   = 0;
    logic [W-1:0] m_a, m_b, m_res;
    logic [1:0]   m_op;

    int done_idx_q[$];
    int done_cyc_q[$];

    logic_unit_arbiter #(.N(N), .WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .op_a   (op_a),
        .op_b   (op_b),
        .opcode (opcode),
        .gnt    (gnt),
        .done   (done),
        .result (result),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_left = 0;
            m_ptr  = 0;
            m_res  = '0;
        end else if (m_left == 0) begin
            if (req != '0) begin
                for (int k = N - 1; k >= 0; k--) begin
                    if (req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
                end
                m_a    = op_a[m_owner*W +: W];
                m_b    = op_b[m_owner*W +: W];
                m_op   = opcode[m_owner*2 +: 2];
                m_left = 2;
            end
        end else if (m_left == 2) begin
            m_res  = ref_op(m_op, m_a, m_b);
            m_left = 1;
        end else begin
            m_ptr  = (m_owner + 1) % N;
            m_left = 0;
        end
    endtask

    function automatic logic [31:0] exp_gnt();
        return (m_left != 0) ? (32'd1 << m_owner) : 32'd0;
    endfunction

    function automatic logic [31:0] exp_done();
        return (m_left == 1) ? (32'd1 << m_owner) : 32'd0;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        cyc++;
        chk("gnt", 32'(gnt), exp_gnt());
        chk("done", 32'(done), exp_done());
        chk("busy", 32'(busy), 32'(m_left != 0));
        chk("result", 32'(result), 32'(m_res));
    endtask

    function automatic int onehot_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        req    = '0;
        op_a   = '0;
        op_b   = '0;
        opcode = '0;
        m_a = '0; m_b = '0; m_res = '0; m_op = '0;
        tick();
        tick();
        chk("reset_gnt", 32'(gnt), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_result", 32'(result), 32'd0);
        rst = 1'b0;

        // 1: single AND op from requester 0
        req = 4'b0001;
        op_a[0 +: W] = 8'hF0; op_b[0 +: W] = 8'h3C; opcode[0 +: 2] = 2'b00;
        tick();
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_nodone", 32'(done), 32'h0);
        tick();
        chk("t1_done", 32'(done), 32'h1);
        chk("t1_result", 32'(result), 32'h30);
        req = '0;
        tick();
        chk("t1_idle", 32'(busy), 32'd0);

        // 2: remaining opcodes on requester 2
        op_a[2*W +: W] = 8'hAA; op_b[2*W +: W] = 8'h0F;
        for (int i = 1; i < 4; i++) begin
            logic [W-1:0] want;
            want = (i == 1) ? 8'hAF : (i == 2) ? 8'hA5 : 8'hF5;
            opcode[2*2 +: 2] = 2'(i);
            req = 4'b0100;
            tick();
            tick();
            chk("t2_done", 32'(done), 32'h4);
            chk("t2_result", 32'(result), 32'(want));
            req = '0;
            tick();
        end

        // 3: all four contending, each drops after its done
        do_reset();
        for (int i = 0; i < N; i++) begin
            op_a[i*W +: W] = W'(8'h11 * (i + 1));
            op_b[i*W +: W] = 8'hFF;
            opcode[i*2 +: 2] = 2'b00;
        end
        req = 4'b1111;
        done_idx_q.delete(); done_cyc_q.delete();
        for (int c = 0; c < 30 && done_idx_q.size() < 4; c++) begin
            tick();
            if (done != '0) begin
                done_idx_q.push_back(onehot_idx(done));
                done_cyc_q.push_back(cyc);
                req = req & ~done;
            end
        end
        chk("t3_count", 32'(done_idx_q.size()), 32'd4);
        for (int i = 0; i < done_idx_q.size(); i++) begin
            chk("t3_order", 32'(done_idx_q[i]), 32'(i));
            if (i > 0) chk("t3_spacing", 32'(done_cyc_q[i] - done_cyc_q[i-1]), 32'd3);
        end
        req = '0;
        tick();

        // 4: req0 and req2 held forever; grants must alternate
        do_reset();
        req = 4'b0101;
        done_idx_q.delete();
        for (int c = 0; c < 27; c++) begin
            tick();
            if (done != '0) done_idx_q.push_back(onehot_idx(done));
        end
        chk("t4_count", 32'(done_idx_q.size() >= 8), 32'd1);
        for (int i = 0; i < done_idx_q.size(); i++) begin
            chk("t4_alternate", 32'(done_idx_q[i]), (i % 2 == 0) ? 32'd0 : 32'd2);
        end
        req = '0;
        tick();
        tick();

        // 5: operands and req change after capture
        do_reset();
        req = 4'b0001;
        op_a[0 +: W] = 8'h55; op_b[0 +: W] = 8'h33; opcode[0 +: 2] = 2'b10;
        tick();
        op_a[0 +: W] = 8'hFF; opcode[0 +: 2] = 2'b00; req = '0;
        tick();
        chk("t5_done", 32'(done), 32'h1);
        chk("t5_result", 32'(result), 32'h66);
        tick();

        // 6: reset during EXEC aborts, then req3 wins from ptr 0
        req = 4'b1010;
        tick();
        chk("t6_gnt1", 32'(gnt), 32'h2);
        rst = 1'b1;
        tick();
        chk("t6_rst_gnt", 32'(gnt), 32'h0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_done", 32'(done), 32'h0);
        rst = 1'b0;
        req = 4'b1000;
        opcode[3*2 +: 2] = 2'b01; op_a[3*W +: W] = 8'h0C; op_b[3*W +: W] = 8'h30;
        tick();
        chk("t6_gnt3", 32'(gnt), 32'h8);
        tick();
        chk("t6_done3", 32'(done), 32'h8);
        chk("t6_result3", 32'(result), 32'h3C);
        req = '0;
        tick();

        // Random traffic with occasional resets
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (m_left == 1 && m_owner == i && !rst) req[i] = 1'b0;
                else if (!req[i] && ($urandom % 4 == 0)) req[i] = 1'b1;
            end
            op_a   = {$urandom, $urandom};
            op_b   = {$urandom, $urandom};
            opcode = 8'($urandom);
            rst    = ($urandom % 60 == 0);
            tick();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
